// File: rtl/emotion_song_scheduler_pkg.sv
// Shared types and constants for the emotion-driven song scheduler.
// Optional build macro used elsewhere in this slice: SCHED_WAIT_SONG_END_EN.
package music_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_STEP     = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_START    = 3'd4,
    ST_COOLDOWN = 3'd5
  } sched_state_e;

  localparam logic [1:0] EMO_HAPPY     = 2'd0;
  localparam logic [1:0] EMO_SAD       = 2'd1;
  localparam logic [1:0] EMO_CALM      = 2'd2;
  localparam logic [1:0] EMO_ENERGETIC = 2'd3;

  localparam logic [7:0] DEFAULT_SONG_MAP = 8'b11_10_01_00;
  localparam int         MAX_STEPS        = 4;

  // Bits [2e+1:2e] of the map hold the song for emotion e.
  function automatic logic [1:0] map_song(input logic [7:0] song_map, input logic [1:0] emo);
    return song_map[{emo, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/emotion_song_scheduler_if.sv
// Bus between the scheduler and its surroundings: analyzer reports, MCU status/pulses,
// user buttons and status outputs. slave = scheduler side, master = environment side.
interface emotion_song_scheduler_if;
  logic       ai_mode;
  logic       emotion_valid;
  logic [1:0] emotion_code;
  logic [7:0] emotion_conf;
  logic [1:0] song_num;
  logic       playing;
  logic       song_done;
  logic       user_play;
  logic       user_next;
  logic       mcu_play;
  logic       mcu_next;
  logic [1:0] target_song;
  logic       busy;
  logic [7:0] switch_count;
  logic       sched_error;

  modport slave (
    input  ai_mode, emotion_valid, emotion_code, emotion_conf,
    input  song_num, playing, song_done, user_play, user_next,
    output mcu_play, mcu_next, target_song, busy, switch_count, sched_error
  );

  modport master (
    output ai_mode, emotion_valid, emotion_code, emotion_conf,
    output song_num, playing, song_done, user_play, user_next,
    input  mcu_play, mcu_next, target_song, busy, switch_count, sched_error
  );
endinterface

// File: rtl/emotion_song_scheduler_debounce.sv
// Emotion report debouncer: tracks a candidate code and how many consecutive
// confident reports agreed with it; raises accept once it is stable and the FSM is idle.
module emotion_debounce
  import music_sched_pkg::*;
#(
  parameter logic [7:0] CONF_THRESH  = 8'd128,
  parameter int         STABLE_COUNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ai_mode,
  input  logic       emotion_valid,
  input  logic [1:0] emotion_code,
  input  logic [7:0] emotion_conf,
  input  logic       user_pulse,
  input  logic       idle,
  output logic       accept,
  output logic [1:0] candidate
);

  localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

  logic [3:0] count;
  logic       qualify;

  assign qualify = emotion_valid && (emotion_conf >= CONF_THRESH);
  assign accept  = (count == STABLE) && idle && ai_mode && !user_pulse;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      candidate <= EMO_HAPPY;
    end else if (!ai_mode || user_pulse || accept) begin
      count <= '0;
    end else if (qualify) begin
      if (emotion_code == candidate) begin
        if (count != STABLE) count <= count + 4'd1;
      end else begin
        candidate <= emotion_code;
        count     <= 4'd1;
      end
    end
  end

endmodule

// File: rtl/emotion_song_scheduler.sv
// Steps the MCU to the song mapped from the debounced emotion, yielding to user buttons.
// Define SCHED_WAIT_SONG_END_EN to hold a pending switch until the current song ends.
module emotion_song_scheduler
  import music_sched_pkg::*;
#(
  parameter logic [7:0] CONF_THRESH     = 8'd128,
  parameter int         STABLE_COUNT    = 3,
  parameter logic [7:0] SONG_MAP        = DEFAULT_SONG_MAP,
  parameter int         STEP_GAP        = 16,
  parameter int         COOLDOWN_CYCLES = 1024
) (
  input logic                      clk,
  input logic                      reset,
  emotion_song_scheduler_if.slave  bus
);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] ARMED    = ST_ARMED;
  localparam logic [2:0] STEP     = ST_STEP;
  localparam logic [2:0] SETTLE   = ST_SETTLE;
  localparam logic [2:0] START    = ST_START;
  localparam logic [2:0] COOLDOWN = ST_COOLDOWN;

  localparam int            GW         = $clog2(STEP_GAP + 1);
  localparam int            CW         = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STEP_GAP - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [2:0]    STEP_LIMIT = 3'(MAX_STEPS);

  logic [2:0]    state;
  logic [2:0]    step_cnt;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] cool_cnt;
  logic          user_pulse;
  logic          accept;
  logic          arm_go;
  logic          sched_next;
  logic          sched_play;
  logic [1:0]    candidate;
  logic [1:0]    mapped;

  assign user_pulse = bus.user_play | bus.user_next;
  assign mapped     = map_song(SONG_MAP, candidate);
  assign sched_next = (state == STEP) && bus.ai_mode && !user_pulse;
  assign sched_play = (state == START) && !bus.playing && bus.ai_mode && !user_pulse;
  assign bus.busy   = (state != IDLE) && (state != COOLDOWN);

`ifdef SCHED_WAIT_SONG_END_EN
  assign arm_go = !bus.playing || bus.song_done;
`else
  assign arm_go = 1'b1;
`endif

  emotion_debounce #(
    .CONF_THRESH  (CONF_THRESH),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .ai_mode       (bus.ai_mode),
    .emotion_valid (bus.emotion_valid),
    .emotion_code  (bus.emotion_code),
    .emotion_conf  (bus.emotion_conf),
    .user_pulse    (user_pulse),
    .idle          (state == IDLE),
    .accept        (accept),
    .candidate     (candidate)
  );

  // User buttons and ai_mode dropping take priority over any scheduling step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      step_cnt         <= '0;
      gap_cnt          <= '0;
      cool_cnt         <= '0;
      bus.mcu_next     <= 1'b0;
      bus.mcu_play     <= 1'b0;
      bus.target_song  <= '0;
      bus.switch_count <= '0;
      bus.sched_error  <= 1'b0;
    end else begin
      bus.mcu_next <= bus.user_next | sched_next;
      bus.mcu_play <= bus.user_play | sched_play;
      if (!bus.ai_mode) begin
        state <= IDLE;
      end else if (user_pulse && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            bus.target_song <= mapped;
            step_cnt        <= '0;
            if (mapped != bus.song_num) state <= ARMED;
          end
          ARMED: if (arm_go) state <= STEP;
          STEP: begin
            step_cnt <= step_cnt + 3'd1;
            gap_cnt  <= '0;
            state    <= SETTLE;
          end
          SETTLE: if (gap_cnt == GAP_LAST) begin
            if (bus.song_num == bus.target_song) begin
              state <= START;
            end else if (step_cnt < STEP_LIMIT) begin
              state <= STEP;
            end else begin
              bus.sched_error <= 1'b1;
              cool_cnt        <= '0;
              state           <= COOLDOWN;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          START: begin
            if (bus.switch_count != 8'hFF) bus.switch_count <= bus.switch_count + 8'd1;
            cool_cnt <= '0;
            state    <= COOLDOWN;
          end
          COOLDOWN: if (cool_cnt == COOL_LAST) state <= IDLE;
                    else cool_cnt <= cool_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/emotion_song_scheduler.md
Name: emotion_song_scheduler

Overview:
- Controller that closes the loop between the AI emotion analyzer and the song-selection MCU.
- Debounces emotion reports, maps the winning emotion to a song, and steps the MCU to that song with registered next/play pulses.
- Arbitrates against the user play/next buttons; user input always wins.
- Sits between the button debouncers, the analyzer outputs and the mcu instance inside the music player.

Parameters:
- CONF_THRESH, 8'd128: minimum emotion_conf for a report to count.
- STABLE_COUNT, 3: consecutive qualifying reports with the same code needed to accept an emotion (1..15).
- SONG_MAP, 8'b11_10_01_00: 2-bit song index per emotion code; bits [2e+1:2e] hold the song for emotion e.
- STEP_GAP, 16: cycles to wait after each next pulse before sampling song_num (>=2).
- COOLDOWN_CYCLES, 1024: minimum spacing between completed automatic switches.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ai_mode  in  1  enables automatic scheduling.
- emotion_valid  in  1  one-cycle strobe: new emotion report.
- emotion_code  in  2  reported emotion.
- emotion_conf  in  8  report confidence.
- song_num  in  2  current song from the MCU.
- playing  in  1  MCU play state.
- song_done  in  1  one-cycle end-of-song strobe.
- user_play  in  1  debounced play button pulse.
- user_next  in  1  debounced next button pulse.
- mcu_play  out  1  play pulse to the MCU.
- mcu_next  out  1  next pulse to the MCU.
- target_song  out  2  song currently being scheduled.
- busy  out  1  high in any state other than IDLE or COOLDOWN.
- switch_count  out  8  completed automatic switches; saturates at 255.
- sched_error  out  1  sticky flag: step timeout occurred.

Behaviour:
- Reset (reset==0 at a clk edge) behaviour:
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Debounce counter and candidate code clear.
  - Applies mid-operation with no residual pulses.
- Output registration: mcu_play and mcu_next are registered. Their value is the OR of the user pulse and the scheduler pulse, delayed by one cycle.
- Qualifying report: emotion_valid=1 and emotion_conf >= CONF_THRESH.
- Debounce, on each qualifying report:
  - Same code as the candidate: the counter increments, saturating at STABLE_COUNT.
  - Different code: the candidate takes the new code and the counter becomes 1.
  - A non-qualifying emotion_valid leaves the counter and candidate unchanged.
  - The counter clears when ai_mode=0 and on any user pulse.
- Acceptance: counter==STABLE_COUNT and FSM in IDLE. target_song <= SONG_MAP[candidate]. The counter clears on acceptance.
  - If target_song == song_num: no action, stay IDLE.
  - Otherwise go to ARMED.
- FSM states: IDLE, ARMED, STEP, SETTLE, START, COOLDOWN.
  - IDLE: waits for acceptance.
  - ARMED: goes to STEP on the next cycle (see Optional Feature).
  - STEP: issues one scheduler next pulse, increments the step counter (0..4), then goes to SETTLE.
  - SETTLE: waits STEP_GAP cycles, then compares song_num with target_song.
    - Equal: go to START.
    - Not equal and step counter < 4: go to STEP.
    - Not equal and step counter == 4: set sched_error, go to COOLDOWN.
  - START: if playing==0, issue one scheduler play pulse. switch_count++ (saturating). Then go to COOLDOWN.
  - COOLDOWN: waits COOLDOWN_CYCLES, then goes to IDLE. Reports are still debounced here; acceptance waits for IDLE.
- Abort conditions:
  - A user_play or user_next pulse in any non-IDLE state aborts to IDLE with no COOLDOWN. The user pulse passes through.
  - A scheduler pulse due in the same cycle as a user pulse is suppressed. mcu_next never pulses twice in one cycle.
  - ai_mode falling in any state sends the FSM to IDLE next cycle. No further scheduler pulses are issued.
- Width and wrap rules:
  - Song index wraps 3 -> 0 inside the MCU; 4 steps cover all songs.
  - The COOLDOWN counter is $clog2(COOLDOWN_CYCLES+1) bits wide.

Optional Feature:
- Macro: SCHED_WAIT_SONG_END_EN.
- Defined: ARMED holds while playing==1 until a song_done strobe, then goes to STEP. If playing==0, ARMED goes to STEP immediately. A user pulse in ARMED aborts as above.
- Not defined: ARMED always goes to STEP on the next cycle.

Decomposition:
- Package music_sched_pkg holds:
  - the FSM state enum (3-bit);
  - emotion code constants EMO_HAPPY=0, EMO_SAD=1, EMO_CALM=2, EMO_ENERGETIC=3;
  - the default SONG_MAP constant;
  - the MAX_STEPS=4 constant.
- One sub-module, emotion_debounce, holds the candidate register, the counter, the threshold compare and the accept strobe. The FSM, timers and output arbitration stay in the top.

Test Plan:
- Basic switch: reset released, ai_mode=1, song_num=0, playing=1. Three emotion_valid with code=2, conf=200 -> target_song=2, exactly two mcu_next pulses ≥STEP_GAP apart (bench model increments song_num); no mcu_play; switch_count=1.
- Low confidence: three reports with code=1, conf=100 -> no mcu_next; busy stays 0.
- Mixed codes: reports 1,1,3,3,3 at conf=200 -> acceptance only after the third 3; target_song=3.
- User override: during SETTLE, assert user_next -> mcu_next pulses exactly once one cycle later; FSM returns to IDLE; no further scheduler pulses.
- Stuck MCU: model ignores next pulses -> four mcu_next pulses, then sched_error=1, COOLDOWN entered, switch_count unchanged.
- Wait for song end (SCHED_WAIT_SONG_END_EN defined): accepted switch with playing=1 -> no mcu_next until song_done strobes; mcu_next goes high in the second cycle after song_done (one cycle to STEP, one cycle of output registration). Reset asserted mid-STEP clears all outputs on the next edge.
